// File: rtl/rom_table_pkg.sv
// Shared constant lookup table, its geometry and the reverse-search FSM states.
// Both the forward decoder and the reverse search index ROM_TABLE so they cannot diverge.
package rom_table_pkg;

    localparam int TABLE_DEPTH = 32;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 8;

    localparam logic [DATA_W-1:0] ROM_TABLE [TABLE_DEPTH] = '{
        8'h83, 8'h05, 8'h09, 8'h0D, 8'h11, 8'h19, 8'h21, 8'hB4,
        8'hC0, 8'hB1, 8'h35, 8'h72, 8'hE3, 8'h3F, 8'h55, 8'h34,
        8'hB0, 8'h11, 8'hB3, 8'h2B, 8'hEE, 8'h77, 8'h75, 8'h43,
        8'h5C, 8'h14, 8'h33, 8'h25, 8'h4E, 8'h74, 8'hE5, 8'h7E
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rom_table_rd.sv
// Registered read port onto the shared constant table.
// Latency: rd_data_o reflects rd_addr_i sampled at the previous rising edge; no backpressure.
module rom_table_rd
    import rom_table_pkg::*;
(
    input  logic              clock_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clock_i) begin
        rd_data_q <= ROM_TABLE[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rom_reverse_lookup.sv
// Reverse search: scans all table addresses for key, reports lowest match and match count.
// Latency: done 33 cycles after the accepted start; start outside IDLE is dropped, not queued.
module rom_reverse_lookup
    import rom_table_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] key_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              found_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W:0]   match_count_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] cmp_addr;

    rom_table_rd u_rd (
        .clock_i   (clock_i),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (rd_data)
    );

    // cnt_q counts scan edges; the word on rd_data belongs to address cnt_q-1 once cnt_q >= 1.
    assign cmp_addr = ADDR_W'(cnt_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        found_d   = found_q;
        addr_d    = addr_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = SCAN;
                    key_d     = key_i;
                    found_d   = 1'b0;
                    addr_d    = '0;
                    count_d   = '0;
                    rd_addr_d = '0;
                    cnt_d     = '0;
                end
            end
            SCAN: begin
                cnt_d = cnt_q + 1'b1;
                if (rd_addr_q != ADDR_W'(TABLE_DEPTH - 1)) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
                if (cnt_q != '0 && rd_data == key_q) begin
                    count_d = count_q + 1'b1;
                    if (!found_q) begin
                        found_d = 1'b1;
                        addr_d  = cmp_addr;
                    end
                end
                if (cnt_q == (ADDR_W + 1)'(TABLE_DEPTH)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            key_q     <= '0;
            found_q   <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            found_q   <= found_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            done_q    <= (state_d == DONE);
        end
    end

    assign busy_o        = (state_q == SCAN);
    assign done_o        = done_q;
    assign found_o       = found_q;
    assign addr_o        = addr_q;
    assign match_count_o = count_q;

endmodule
